// File: rtl/brent_kung_bist_if.sv
// ----------------------------------------------------------------------------
// brent_kung_bist_if
//   Bundle between the Brent-Kung adder self-test engine and its environment.
//   The engine drives the adder operands and the status outputs; it consumes
//   the start pulse and the adder result.
//
//   Signals
//     start           run request pulse (environment -> engine)
//     busy, done      run status
//     pass            result valid with done; 1 = no mismatching vector
//     err_count       number of mismatching vectors (saturating)
//     first_fail_idx  index of the first mismatching vector of the run
//     dut_a, dut_b    registered adder operands
//     dut_cin         registered adder carry-in
//     dut_sum         adder sum       (adder -> engine)
//     dut_cout        adder carry_out (adder -> engine)
//
//   Modports
//     master  the self-test engine
//     slave   the environment: start source plus the adder under test
// ----------------------------------------------------------------------------
interface brent_kung_bist_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [15:0]      first_fail_idx;
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  modport master (
    input  start, dut_sum, dut_cout,
    output busy, done, pass, err_count, first_fail_idx,
           dut_a, dut_b, dut_cin
  );

  modport slave (
    output start, dut_sum, dut_cout,
    input  busy, done, pass, err_count, first_fail_idx,
           dut_a, dut_b, dut_cin
  );
endinterface

// File: rtl/brent_kung_bist.sv
// ----------------------------------------------------------------------------
// brent_kung_bist
//   Built-in self-test for a WIDTH-bit Brent-Kung adder. Applies four fixed
//   corner vectors followed by LFSR-generated vectors, waits LAT+1 cycles for
//   the adder to settle, compares {cout,sum} against a+b+cin and accumulates
//   an error count and the index of the first failing vector.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   brent_kung_bist_if.master: start/busy/done/pass, err_count,
//           first_fail_idx, adder operands out, adder result in
//
//   Each vector takes LAT+3 cycles: APPLY (1), SETTLE (LAT+1), CHECK (1).
// ----------------------------------------------------------------------------
module brent_kung_bist #(
  parameter int          WIDTH       = 16,
  parameter int          NUM_VECTORS = 256,
  parameter int          LAT         = 0,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              rst,
  brent_kung_bist_if.master bus
);

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam int          CW   = $clog2(LAT + 2);
  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      idx_q, idx_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      ffi_q, ffi_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;

  logic [WIDTH-1:0] vec_a;
  logic [WIDTH-1:0] vec_b;
  logic             vec_cin;
  logic [WIDTH:0]   expected;
  logic             mismatch;

  // Operand pattern for the current index: corners first, then LFSR halves.
  always_comb begin
    vec_a   = WIDTH'(lfsr_q[31:16]);
    vec_b   = WIDTH'(lfsr_q[15:0]);
    vec_cin = idx_q[0];
    case (idx_q)
      16'd0: begin
        vec_a   = '1;
        vec_b   = WIDTH'(1);
        vec_cin = 1'b0;
      end
      16'd1: begin
        vec_a   = '1;
        vec_b   = '1;
        vec_cin = 1'b1;
      end
      16'd2: begin
        vec_a   = '0;
        vec_b   = '0;
        vec_cin = 1'b0;
      end
      16'd3: begin
        vec_a   = {1'b1, {(WIDTH-1){1'b0}}};
        vec_b   = {1'b1, {(WIDTH-1){1'b0}}};
        vec_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign expected = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign mismatch = ({bus.dut_cout, bus.dut_sum} != expected);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    pass_d   = pass_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_APPLY;
          idx_d   = '0;
          lfsr_d  = SEED;
          err_d   = '0;
          ffi_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_APPLY: begin
        a_d      = vec_a;
        b_d      = vec_b;
        cin_d    = vec_cin;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == CW'(LAT)) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          // err_q still zero means this is the first failure of the run.
          if (err_q == 16'd0) ffi_d = idx_q;
        end
        // The first random vector uses SEED itself, so advance after use.
        if (idx_q >= 16'd4) begin
          lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
        end
        if (idx_q == LAST) begin
          state_d = S_DONE;
          pass_d  = !mismatch && (err_q == 16'd0);
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lfsr_q   <= SEED;
      settle_q <= '0;
      err_q    <= '0;
      ffi_q    <= '0;
      pass_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lfsr_q   <= lfsr_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffi_q    <= ffi_d;
      pass_q   <= pass_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
    end
  end

  assign bus.busy           = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                              (state_q == S_CHECK);
  assign bus.done           = (state_q == S_DONE);
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.dut_a          = a_q;
  assign bus.dut_b          = b_q;
  assign bus.dut_cin        = cin_q;

endmodule
